pc_stage_predictor: RTL and testbench
=====================================

Name: pc_stage_predictor

Overview:
- Parametrised next-generation program-counter stage with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- Predicts the next fetch PC every cycle.
- Resolves branches, JAL and JALR in execute, corrects the PC on a mispredict and issues decode/execute flushes.
- Sits at the pipeline front: drives the instruction-memory address and passes prediction tags down to execute.

Parameters:
- XLEN, 32, address/data width.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2.
- ALU_JAL, 5'b01010, ALU opcode for JAL.
- ALU_JALR, 5'b01011, ALU opcode for JALR.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-high
- STALL_FETCH  in  1  hold PC (hazard in decode)
- STALL_EXECUTION_STAGE  in  1  execute stalled; no resolution this cycle
- EX_VALID  in  1  execute holds a real (non-bubble) instruction
- EX_IS_BRANCH  in  1  execute instruction is a conditional branch
- ALU_INSTRUCTION  in  5  execute ALU opcode
- BRANCH_TAKEN  in  1  branch comparator result
- PC_EXECUTION  in  XLEN  PC of the execute instruction
- RS1_DATA  in  XLEN  forwarded rs1
- IMM_INPUT  in  XLEN  sign-extended immediate
- EX_PRED_TAKEN  in  1  prediction carried with the execute instruction
- EX_PRED_TARGET  in  XLEN  predicted target carried with it
- PC  out  XLEN  current fetch PC
- PRED_TAKEN  out  1  prediction for PC (pipelined by decode)
- PRED_TARGET  out  XLEN  predicted target for PC
- CLEAR_DECODING_STAGE  out  1  flush decode register
- CLEAR_EXECUTION_STAGE  out  1  flush execute register

Behaviour:
- Reset (async, RST=1):
  - PC = RESET_VECTOR; all BTB valid bits = 0; counters = 2'b01.
  - Outputs PRED_TAKEN=0 and both CLEARs=0 (combinational from reset state).
- Lookup (combinational on PC):
  - index = PC[log2(BTB_ENTRIES)+1:2]; tag = PC[XLEN-1:log2(BTB_ENTRIES)+2].
  - hit = valid && tag match.
  - PRED_TAKEN = hit && ctr[1]. PRED_TARGET = entry target when hit, else PC+4.
- Resolve: active only when EX_VALID && !STALL_EXECUTION_STAGE && (EX_IS_BRANCH || opcode == JAL/JALR).
  - Actual taken: branch → BRANCH_TAKEN; JAL/JALR → 1.
  - Actual target:
    - JAL and branches: PC_EXECUTION+IMM_INPUT.
    - JALR: (RS1_DATA+IMM_INPUT) & ~1.
    - Not-taken branch: PC_EXECUTION+4.
  - All adds are XLEN-bit modulo; wrap-around is ignored.
  - mispredict = (actual_taken != EX_PRED_TAKEN) || (actual_taken && target != EX_PRED_TARGET).
  - A non-control instruction in execute with EX_PRED_TAKEN=1 (stale alias) is also a mispredict; redirect to PC_EXECUTION+4.
- Redirect:
  - On mispredict, CLEAR_DECODING_STAGE = CLEAR_EXECUTION_STAGE = 1 combinationally in the same cycle.
  - At the next edge, PC <= correct target (taken) or PC_EXECUTION+4 (not taken).
- Next-PC priority at each edge:
  1. Redirect (overrides STALL_FETCH).
  2. STALL_FETCH: hold PC.
  3. Otherwise PC <= PRED_TARGET.
- BTB update (at the edge, on resolve), index/tag taken from PC_EXECUTION:
  - JAL/JALR: write entry, valid=1, target, ctr=2'b11.
  - Branch, hit: ctr saturating +1 if taken, -1 if not; target rewritten when taken.
  - Branch, miss, taken: allocate, ctr=2'b10. Miss, not taken: no write.
- Same-cycle lookup/update on the same index: the lookup sees the old contents (write-after-read).
- RST asserted mid-operation: immediate return to the reset state; no partial BTB write survives.
- Latency: prediction 0 cycles; mispredict penalty 2 cycles (decode + execute flushed).

Decomposition:
- Shared package (riscv_pkg): ALU_JAL/ALU_JALR opcode constants, 2-bit counter encodings (SNT=00, WNT=01, WT=10, ST=11), XLEN default.
- One sub-module: branch_target_buffer.
  - Holds valid/tag/target/counter arrays.
  - Combinational read port, synchronous write port, async reset of valid bits.
- Resolution and next-PC muxing stay in pc_stage_predictor.

Test Plan:
- Reset with RESET_VECTOR=0x100, then release, no control flow → PC 0x100, 0x104, 0x108 on successive edges; PRED_TAKEN=0; CLEARs never asserted.
- Taken branch at 0x200, IMM=-16, EX_PRED_TAKEN=0 → both CLEARs high that cycle; next PC=0x1F0; BTB[0x200] ctr=10. Re-fetch of 0x200 → PRED_TAKEN=1, PRED_TARGET=0x1F0. Correct resolve → no flush.
- Loop branch: taken ×3, then not-taken once, then taken:
  - Counter sequence 10→11→11→10→11.
  - Only the not-taken resolution flushes; redirect to PC_EXECUTION+4.
- JALR with RS1=0x3001, IMM=2 → target 0x3002 (bit0 cleared); entry written with ctr=11; second execution predicted correctly with no flush.
- STALL_FETCH=1 plus a simultaneous mispredict → PC takes the redirect target; STALL_FETCH alone holds PC for N cycles unchanged. STALL_EXECUTION_STAGE=1 with a mispredicting branch → no flush and no BTB write until the stall drops.
- RST pulsed mid-loop after the BTB is trained → PC=RESET_VECTOR asynchronously; subsequent fetch of the trained PC gives PRED_TAKEN=0.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared constants and helpers for the fetch / branch-prediction
//            front end: ALU opcodes for JAL/JALR, 2-bit direction-counter
//            encodings, default datapath width and the saturating counter
//            update function.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [4:0] OPC_JAL  = 5'b01010;
  localparam logic [4:0] OPC_JALR = 5'b01011;

  // Direction counter: the upper bit is the taken/not-taken prediction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Saturating +1 on taken, -1 on not taken.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] result;
    result = ctr;
    if (taken && (ctr != CTR_ST)) begin
      result = ctr + 2'd1;
    end else if (!taken && (ctr != CTR_SNT)) begin
      result = ctr - 2'd1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_buffer
// Purpose  : Direct-mapped BTB holding valid / tag / target / 2-bit counter
//            per entry. Two combinational read ports (fetch lookup and
//            execute-side lookup used to compute the update) and one
//            synchronous write port. Valid bits and counters reset
//            asynchronously; tags and targets are don't-care while invalid.
// Ports    : clk, rst            - clock, async active-high reset
//            fetch_wa            - fetch PC word address (PC[XLEN-1:2])
//            fetch_hit/ctr/target- fetch lookup result
//            ex_wa               - execute PC word address
//            ex_hit/ctr/target   - execute-side lookup result
//            wr_en/wr_wa/wr_target/wr_ctr - write port (sets valid)
// Revision : 1.0 - initial release
// ============================================================================
module branch_target_buffer
  import riscv_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-3:0] fetch_wa,
  output logic            fetch_hit,
  output logic [1:0]      fetch_ctr,
  output logic [XLEN-1:0] fetch_target,
  input  logic [XLEN-3:0] ex_wa,
  output logic            ex_hit,
  output logic [1:0]      ex_ctr,
  output logic [XLEN-1:0] ex_target,
  input  logic            wr_en,
  input  logic [XLEN-3:0] wr_wa,
  input  logic [XLEN-1:0] wr_target,
  input  logic [1:0]      wr_ctr
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - 2 - IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [1:0]         ctr        [ENTRIES];
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [XLEN-1:0]    target_mem [ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;

  assign fetch_idx = fetch_wa[IDX_W-1:0];
  assign fetch_tag = fetch_wa[XLEN-3:IDX_W];
  assign ex_idx    = ex_wa[IDX_W-1:0];
  assign ex_tag    = ex_wa[XLEN-3:IDX_W];
  assign wr_idx    = wr_wa[IDX_W-1:0];
  assign wr_tag    = wr_wa[XLEN-3:IDX_W];

  // Reads are purely combinational, so a same-cycle write to the same entry
  // is only visible from the following cycle on.
  assign fetch_hit    = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
  assign fetch_ctr    = ctr[fetch_idx];
  assign fetch_target = target_mem[fetch_idx];

  assign ex_hit    = valid[ex_idx] && (tag_mem[ex_idx] == ex_tag);
  assign ex_ctr    = ctr[ex_idx];
  assign ex_target = target_mem[ex_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= CTR_WNT;
      end
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
      ctr[wr_idx]   <= wr_ctr;
    end
  end

  // Payload needs no reset: an entry is only consulted once its valid bit
  // has been set by a complete write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]    <= wr_tag;
      target_mem[wr_idx] <= wr_target;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_stage_predictor.sv
`default_nettype none
// ============================================================================
// Module   : pc_stage_predictor
// Purpose  : Program-counter stage with BTB-based next-PC prediction and
//            execute-stage branch/JAL/JALR resolution. On a mispredict the
//            decode and execute registers are flushed in the same cycle and
//            the PC is redirected at the next edge.
// Ports    : CLK, RST (async, active-high)
//            STALL_FETCH, STALL_EXECUTION_STAGE - pipeline stalls
//            EX_* / ALU_INSTRUCTION / BRANCH_TAKEN / PC_EXECUTION /
//            RS1_DATA / IMM_INPUT                - execute-stage resolution
//            PC, PRED_TAKEN, PRED_TARGET         - fetch address + prediction
//            CLEAR_DECODING_STAGE, CLEAR_EXECUTION_STAGE - flushes
// Revision : 1.0 - initial release
// ============================================================================
module pc_stage_predictor
  import riscv_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BTB_ENTRIES  = 16,
  parameter logic [4:0]      ALU_JAL      = OPC_JAL,
  parameter logic [4:0]      ALU_JALR     = OPC_JALR
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STALL_FETCH,
  input  logic            STALL_EXECUTION_STAGE,
  input  logic            EX_VALID,
  input  logic            EX_IS_BRANCH,
  input  logic [4:0]      ALU_INSTRUCTION,
  input  logic            BRANCH_TAKEN,
  input  logic [XLEN-1:0] PC_EXECUTION,
  input  logic [XLEN-1:0] RS1_DATA,
  input  logic [XLEN-1:0] IMM_INPUT,
  input  logic            EX_PRED_TAKEN,
  input  logic [XLEN-1:0] EX_PRED_TARGET,
  output logic [XLEN-1:0] PC,
  output logic            PRED_TAKEN,
  output logic [XLEN-1:0] PRED_TARGET,
  output logic            CLEAR_DECODING_STAGE,
  output logic            CLEAR_EXECUTION_STAGE
);

  localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(4);

  logic            fetch_hit;
  logic [1:0]      fetch_ctr;
  logic [XLEN-1:0] fetch_target;
  logic            ex_hit;
  logic [1:0]      ex_ctr;
  logic [XLEN-1:0] ex_target;
  logic            wr_en;
  logic [XLEN-1:0] wr_target;
  logic [1:0]      wr_ctr;

  logic            is_jal;
  logic            is_jalr;
  logic            is_jump;
  logic            is_branch;
  logic            ex_active;
  logic            resolve;
  logic            stale_alias;
  logic            actual_taken;
  logic [XLEN-1:0] taken_target;
  logic [XLEN-1:0] seq_target;
  logic [XLEN-1:0] redirect_pc;
  logic            mispredict;

  branch_target_buffer #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk          (CLK),
    .rst          (RST),
    .fetch_wa     (PC[XLEN-1:2]),
    .fetch_hit    (fetch_hit),
    .fetch_ctr    (fetch_ctr),
    .fetch_target (fetch_target),
    .ex_wa        (PC_EXECUTION[XLEN-1:2]),
    .ex_hit       (ex_hit),
    .ex_ctr       (ex_ctr),
    .ex_target    (ex_target),
    .wr_en        (wr_en),
    .wr_wa        (PC_EXECUTION[XLEN-1:2]),
    .wr_target    (wr_target),
    .wr_ctr       (wr_ctr)
  );

  // Fetch-side prediction: zero-cycle lookup on the current PC.
  assign PRED_TAKEN  = fetch_hit && ((fetch_ctr == CTR_WT) || (fetch_ctr == CTR_ST));
  assign PRED_TARGET = fetch_hit ? fetch_target : (PC + INSN_BYTES);

  // Execute-side resolution. A jump opcode takes precedence over the branch
  // flag should both ever be presented together.
  assign is_jal    = (ALU_INSTRUCTION == ALU_JAL);
  assign is_jalr   = (ALU_INSTRUCTION == ALU_JALR);
  assign is_jump   = is_jal || is_jalr;
  assign is_branch = EX_IS_BRANCH && !is_jump;

  assign ex_active   = EX_VALID && !STALL_EXECUTION_STAGE;
  assign resolve     = ex_active && (is_branch || is_jump);
  // A non-control instruction that was fetched with a taken prediction came
  // from a BTB alias; the fetch stream after it is wrong.
  assign stale_alias = ex_active && !(is_branch || is_jump) && EX_PRED_TAKEN;

  assign actual_taken = is_jump || BRANCH_TAKEN;
  assign taken_target = is_jalr ? ((RS1_DATA + IMM_INPUT) & ~XLEN'(1))
                                : (PC_EXECUTION + IMM_INPUT);
  assign seq_target   = PC_EXECUTION + INSN_BYTES;
  assign redirect_pc  = (resolve && actual_taken) ? taken_target : seq_target;

  assign mispredict = stale_alias ||
                      (resolve && ((actual_taken != EX_PRED_TAKEN) ||
                                   (actual_taken && (taken_target != EX_PRED_TARGET))));

  assign CLEAR_DECODING_STAGE  = mispredict;
  assign CLEAR_EXECUTION_STAGE = mispredict;

  // BTB update policy.
  always_comb begin
    wr_en     = 1'b0;
    wr_ctr    = ex_ctr;
    wr_target = ex_target;
    if (resolve) begin
      if (is_jump) begin
        wr_en     = 1'b1;
        wr_ctr    = CTR_ST;
        wr_target = taken_target;
      end else if (ex_hit) begin
        wr_en  = 1'b1;
        wr_ctr = ctr_next(ex_ctr, BRANCH_TAKEN);
        if (BRANCH_TAKEN) begin
          wr_target = taken_target;
        end
      end else if (BRANCH_TAKEN) begin
        wr_en     = 1'b1;
        wr_ctr    = CTR_WT;
        wr_target = taken_target;
      end
    end
  end

  // Next PC: redirect beats a fetch stall, otherwise follow the prediction.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PC <= RESET_VECTOR;
    end else if (mispredict) begin
      PC <= redirect_pc;
    end else if (!STALL_FETCH) begin
      PC <= PRED_TARGET;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_stage_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_stage_predictor
// Purpose  : Self-checking bench for pc_stage_predictor. Each cycle the
//            stimulus pushes the expected fetch-side outputs to a queue; a
//            monitor pops and compares them mid-cycle. BTB counters and valid
//            bits are additionally inspected after selected edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_stage_predictor;
  import riscv_pkg::*;

  localparam int XLEN = 32;

  logic            CLK = 1'b0;
  logic            RST;
  logic            STALL_FETCH;
  logic            STALL_EXECUTION_STAGE;
  logic            EX_VALID;
  logic            EX_IS_BRANCH;
  logic [4:0]      ALU_INSTRUCTION;
  logic            BRANCH_TAKEN;
  logic [XLEN-1:0] PC_EXECUTION;
  logic [XLEN-1:0] RS1_DATA;
  logic [XLEN-1:0] IMM_INPUT;
  logic            EX_PRED_TAKEN;
  logic [XLEN-1:0] EX_PRED_TARGET;
  logic [XLEN-1:0] PC;
  logic            PRED_TAKEN;
  logic [XLEN-1:0] PRED_TARGET;
  logic            CLEAR_DECODING_STAGE;
  logic            CLEAR_EXECUTION_STAGE;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string           tag;
    logic [XLEN-1:0] pc;
    logic            pt;
    logic [XLEN-1:0] ptgt;
    logic            clr;
  } exp_t;

  exp_t sb[$];

  pc_stage_predictor #(
    .XLEN         (XLEN),
    .RESET_VECTOR (32'h0000_0100),
    .BTB_ENTRIES  (16),
    .ALU_JAL      (5'b01010),
    .ALU_JALR     (5'b01011)
  ) dut (
    .CLK                   (CLK),
    .RST                   (RST),
    .STALL_FETCH           (STALL_FETCH),
    .STALL_EXECUTION_STAGE (STALL_EXECUTION_STAGE),
    .EX_VALID              (EX_VALID),
    .EX_IS_BRANCH          (EX_IS_BRANCH),
    .ALU_INSTRUCTION       (ALU_INSTRUCTION),
    .BRANCH_TAKEN          (BRANCH_TAKEN),
    .PC_EXECUTION          (PC_EXECUTION),
    .RS1_DATA              (RS1_DATA),
    .IMM_INPUT             (IMM_INPUT),
    .EX_PRED_TAKEN         (EX_PRED_TAKEN),
    .EX_PRED_TARGET        (EX_PRED_TARGET),
    .PC                    (PC),
    .PRED_TAKEN            (PRED_TAKEN),
    .PRED_TARGET           (PRED_TARGET),
    .CLEAR_DECODING_STAGE  (CLEAR_DECODING_STAGE),
    .CLEAR_EXECUTION_STAGE (CLEAR_EXECUTION_STAGE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic br, input logic [4:0] op, input logic tk,
                       input logic [XLEN-1:0] pcx, input logic [XLEN-1:0] rs1,
                       input logic [XLEN-1:0] imm, input logic pt, input logic [XLEN-1:0] ptgt);
    EX_VALID        = v;
    EX_IS_BRANCH    = br;
    ALU_INSTRUCTION = op;
    BRANCH_TAKEN    = tk;
    PC_EXECUTION    = pcx;
    RS1_DATA        = rs1;
    IMM_INPUT       = imm;
    EX_PRED_TAKEN   = pt;
    EX_PRED_TARGET  = ptgt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  // Push this cycle's expected outputs, then advance to the next negedge.
  task automatic step(input string tag, input logic [XLEN-1:0] pc, input logic pt,
                      input logic [XLEN-1:0] ptgt, input logic clr);
    exp_t e;
    e.tag  = tag;
    e.pc   = pc;
    e.pt   = pt;
    e.ptgt = ptgt;
    e.clr  = clr;
    sb.push_back(e);
    @(negedge CLK);
  endtask

  // Monitor: compare mid-cycle, well away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #3;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({e.tag, ".pc"},    PC,                           e.pc);
        check({e.tag, ".ptk"},   {31'd0, PRED_TAKEN},            {31'd0, e.pt});
        check({e.tag, ".ptgt"},  PRED_TARGET,                  e.ptgt);
        check({e.tag, ".clrd"},  {31'd0, CLEAR_DECODING_STAGE},  {31'd0, e.clr});
        check({e.tag, ".clre"},  {31'd0, CLEAR_EXECUTION_STAGE}, {31'd0, e.clr});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST                   = 1'b1;
    STALL_FETCH           = 1'b0;
    STALL_EXECUTION_STAGE = 1'b0;
    idle();
    @(negedge CLK);

    // Reset and free-running sequential fetch
    step("reset", 32'h100, 1'b0, 32'h104, 1'b0);
    RST = 1'b0;
    step("run0", 32'h100, 1'b0, 32'h104, 1'b0);
    step("run1", 32'h104, 1'b0, 32'h108, 1'b0);
    step("run2", 32'h108, 1'b0, 32'h10C, 1'b0);

    // Taken branch at 0x200, unpredicted: flush, redirect to 0x1F0, allocate WT
    drive(1'b1, 1'b1, 5'd0, 1'b1, 32'h200, '0, 32'hFFFF_FFF0, 1'b0, '0);
    step("br_alloc", 32'h10C, 1'b0, 32'h110, 1'b1);

    // JAL at 0x1F0 -> 0x200 to bring fetch back to the trained branch
    check("ctr_alloc", 32'(dut.u_btb.ctr[0]), 32'h2);
    check("valid_alloc", 32'(dut.u_btb.valid[0]), 32'h1);
    drive(1'b1, 1'b0, OPC_JAL, 1'b0, 32'h1F0, '0, 32'h10, 1'b0, '0);
    step("jal", 32'h1F0, 1'b0, 32'h1F4, 1'b1);

    // Loop: taken (correct), taken (correct), not-taken (flush), taken
    drive(1'b1, 1'b1, 5'd0, 1'b1, 32'h200, '0, 32'hFFFF_FFF0, 1'b1, 32'h1F0);
    step("br_hit", 32'h200, 1'b1, 32'h1F0, 1'b0);
    check("ctr_t2", 32'(dut.u_btb.ctr[0]), 32'h3);
    check("ctr_jal", 32'(dut.u_btb.ctr[12]), 32'h3);
    step("jal_hit", 32'h1F0, 1'b1, 32'h200, 1'b0);
    check("ctr_t3", 32'(dut.u_btb.ctr[0]), 32'h3);
    drive(1'b1, 1'b1, 5'd0, 1'b0, 32'h200, '0, 32'hFFFF_FFF0, 1'b1, 32'h1F0);
    step("br_nt", 32'h200, 1'b1, 32'h1F0, 1'b1);
    check("ctr_nt", 32'(dut.u_btb.ctr[0]), 32'h2);
    drive(1'b1, 1'b1, 5'd0, 1'b1, 32'h200, '0, 32'hFFFF_FFF0, 1'b1, 32'h1F0);
    step("br_retake", 32'h204, 1'b0, 32'h208, 1'b0);
    check("ctr_retake", 32'(dut.u_btb.ctr[0]), 32'h3);

    // JALR at 0x40C: (0x3001 + 2) & ~1 = 0x3002
    drive(1'b1, 1'b0, OPC_JALR, 1'b0, 32'h40C, 32'h3001, 32'h2, 1'b0, '0);
    step("jalr", 32'h208, 1'b0, 32'h20C, 1'b1);
    check("ctr_jalr", 32'(dut.u_btb.ctr[3]), 32'h3);
    drive(1'b1, 1'b0, OPC_JALR, 1'b0, 32'h40C, 32'h3001, 32'h2, 1'b1, 32'h3002);
    step("jalr_hit", 32'h3002, 1'b0, 32'h3006, 1'b0);

    // Redirect (stale alias) beats STALL_FETCH
    STALL_FETCH = 1'b1;
    drive(1'b1, 1'b0, 5'd0, 1'b0, 32'h500, '0, '0, 1'b1, 32'h777);
    step("stall_redir", 32'h3006, 1'b0, 32'h300A, 1'b1);
    idle();
    for (int i = 0; i < 3; i++) begin
      step("stall_hold", 32'h504, 1'b0, 32'h508, 1'b0);
    end
    STALL_FETCH = 1'b0;
    step("stall_rel", 32'h504, 1'b0, 32'h508, 1'b0);

    // Execute stall hides a mispredicting branch until released
    STALL_EXECUTION_STAGE = 1'b1;
    drive(1'b1, 1'b1, 5'd0, 1'b1, 32'h608, '0, 32'h20, 1'b0, '0);
    step("exst0", 32'h508, 1'b0, 32'h50C, 1'b0);
    check("exst_nowr0", 32'(dut.u_btb.valid[2]), 32'h0);
    step("exst1", 32'h50C, 1'b0, 32'h510, 1'b0);
    check("exst_nowr1", 32'(dut.u_btb.valid[2]), 32'h0);
    STALL_EXECUTION_STAGE = 1'b0;
    step("exst_rel", 32'h510, 1'b0, 32'h514, 1'b1);
    check("exst_valid", 32'(dut.u_btb.valid[2]), 32'h1);
    check("exst_ctr", 32'(dut.u_btb.ctr[2]), 32'h2);

    // Return to the trained branch, then reset asynchronously
    drive(1'b1, 1'b0, 5'd0, 1'b0, 32'h1FC, '0, '0, 1'b1, '0);
    step("alias", 32'h628, 1'b0, 32'h62C, 1'b1);
    idle();
    step("trained", 32'h200, 1'b1, 32'h1F0, 1'b0);
    RST = 1'b1;
    step("rst_async", 32'h100, 1'b0, 32'h104, 1'b0);
    check("rst_ctr", 32'(dut.u_btb.ctr[0]), 32'h1);
    check("rst_valid", 32'(dut.u_btb.valid[0]), 32'h0);
    RST = 1'b0;
    drive(1'b1, 1'b0, 5'd0, 1'b0, 32'h1FC, '0, '0, 1'b1, '0);
    step("rst_alias", 32'h100, 1'b0, 32'h104, 1'b1);
    idle();
    step("post_rst", 32'h200, 1'b0, 32'h204, 1'b0);

    #5;
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
